// File: rtl/iter_divider.sv
// Iterative restoring divider (DIV/DIVU) with y==0 fast path and flush cancel.
// Latency WIDTH/STEPS_PER_CYCLE+1 cycles (1 for y==0); result held in DONE until out_ready, cancel aborts at any time.
module iter_divider #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CYCLES = WIDTH / STEPS_PER_CYCLE;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] abs_x;
  logic [WIDTH-1:0] abs_y;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign x_neg = div_signed & x[WIDTH-1];
  assign y_neg = div_signed & y[WIDTH-1];
  assign abs_x = x_neg ? -x : x;
  assign abs_y = y_neg ? -y : y;

  // quo shifts dividend bits out at the top while quotient bits enter at the bottom
  always_comb begin
    logic [WIDTH:0] rem_sh;
    logic           borrow;
    rem_n  = rem;
    quo_n  = quo;
    rem_sh = '0;
    borrow = 1'b0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      rem_sh = {rem_n, quo_n[WIDTH-1]};
      borrow = (rem_sh < {1'b0, dvsr});
      rem_n  = borrow ? rem_sh[WIDTH-1:0] : (rem_sh[WIDTH-1:0] - dvsr);
      quo_n  = {quo_n[WIDTH-2:0], ~borrow};
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dvsr        <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      s           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_neg <= x_neg ^ y_neg;
            r_neg <= x_neg;
            dvsr  <= abs_y;
            quo   <= abs_x;
            rem   <= '0;
            cnt   <= '0;
            if (y == '0) begin
              s           <= '1;
              r           <= x;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // most-negative / -1 falls out naturally: magnitude 2^(W-1), no negation
            s           <= q_neg ? -quo_n : quo_n;
            r           <= r_neg ? -rem_n : rem_n;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed and small random checks of iter_divider at 32/1 and 16/4 configurations.
module tb_iter_divider;

  logic        div_clk = 1'b0;
  logic        resetn  = 1'b0;

  logic        a_iv = 1'b0, a_sg = 1'b0, a_cancel = 1'b0, a_or = 1'b0;
  logic [31:0] a_x = '0, a_y = '0;
  logic        a_ir, a_ov, a_dz;
  logic [31:0] a_s, a_r;

  logic        b_iv = 1'b0, b_sg = 1'b0, b_cancel = 1'b0, b_or = 1'b0;
  logic [15:0] b_x = '0, b_y = '0;
  logic        b_ir, b_ov, b_dz;
  logic [15:0] b_s, b_r;

  int checks = 0;
  int errors = 0;

  always #5 div_clk = ~div_clk;

  iter_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u32 (
    .div_clk(div_clk), .resetn(resetn), .in_valid(a_iv), .in_ready(a_ir),
    .div_signed(a_sg), .x(a_x), .y(a_y), .cancel(a_cancel), .out_valid(a_ov),
    .out_ready(a_or), .s(a_s), .r(a_r), .div_by_zero(a_dz));

  iter_divider #(.WIDTH(16), .STEPS_PER_CYCLE(4)) u16 (
    .div_clk(div_clk), .resetn(resetn), .in_valid(b_iv), .in_ready(b_ir),
    .div_signed(b_sg), .x(b_x), .y(b_y), .cancel(b_cancel), .out_valid(b_ov),
    .out_ready(b_or), .s(b_s), .r(b_r), .div_by_zero(b_dz));

  task automatic start32(input logic sg, input logic [31:0] xv, input logic [31:0] yv);
    @(posedge div_clk); #1;
    a_sg = sg; a_x = xv; a_y = yv; a_iv = 1'b1;
    @(posedge div_clk); #1;
    a_iv = 1'b0; a_x = $urandom; a_y = $urandom; a_sg = ~sg;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (!a_ov && lat < 200) begin
      @(posedge div_clk); #1;
      lat++;
    end
  endtask

  task automatic run32(input logic sg, input logic [31:0] xv, input logic [31:0] yv,
                       output logic [31:0] so, output logic [31:0] ro, output logic dz, output int lat);
    start32(sg, xv, yv);
    wait32(lat);
    so = a_s; ro = a_r; dz = a_dz;
    a_or = 1'b1;
    @(posedge div_clk); #1;
    a_or = 1'b0;
  endtask

  task automatic run16(input logic sg, input logic [15:0] xv, input logic [15:0] yv,
                       output logic [15:0] so, output logic [15:0] ro, output logic dz, output int lat);
    @(posedge div_clk); #1;
    b_sg = sg; b_x = xv; b_y = yv; b_iv = 1'b1;
    @(posedge div_clk); #1;
    b_iv = 1'b0; b_x = 16'h5a5a;
    lat = 1;
    while (!b_ov && lat < 200) begin
      @(posedge div_clk); #1;
      lat++;
    end
    so = b_s; ro = b_r; dz = b_dz;
    b_or = 1'b1;
    @(posedge div_clk); #1;
    b_or = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", a_ir); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_ov); end
    checks++; if (a_s !== 32'd0) begin errors++; $display("FAIL reset_s got %h want 0", a_s); end
    checks++; if (a_r !== 32'd0) begin errors++; $display("FAIL reset_r got %h want 0", a_r); end
    checks++; if (a_dz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", a_dz); end
    repeat (2) @(posedge div_clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] so, ro; logic dz; int lat;
    run32(1'b0, 32'd7, 32'd2, so, ro, dz, lat);
    checks++; if (so !== 32'd3) begin errors++; $display("FAIL u7_2_s got %h want 3", so); end
    checks++; if (ro !== 32'd1) begin errors++; $display("FAIL u7_2_r got %h want 1", ro); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL u7_2_dbz got %b want 0", dz); end
    checks++; if (lat != 33) begin errors++; $display("FAIL u7_2_latency got %0d want 33", lat); end
    run32(1'b0, 32'hFFFF_FFFF, 32'd1, so, ro, dz, lat);
    checks++; if (so !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_1_s got %h want ffffffff", so); end
    checks++; if (ro !== 32'd0) begin errors++; $display("FAIL umax_1_r got %h want 0", ro); end
  endtask

  task automatic test_signed();
    logic [31:0] so, ro; logic dz; int lat;
    run32(1'b1, 32'hFFFF_FFF9, 32'd2, so, ro, dz, lat);
    checks++; if (so !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sm7_2_s got %h want fffffffd", so); end
    checks++; if (ro !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sm7_2_r got %h want ffffffff", ro); end
    run32(1'b1, 32'd7, 32'hFFFF_FFFE, so, ro, dz, lat);
    checks++; if (so !== 32'hFFFF_FFFD) begin errors++; $display("FAIL s7_m2_s got %h want fffffffd", so); end
    checks++; if (ro !== 32'd1) begin errors++; $display("FAIL s7_m2_r got %h want 1", ro); end
    run32(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, so, ro, dz, lat);
    checks++; if (so !== 32'd3) begin errors++; $display("FAIL sm7_m2_s got %h want 3", so); end
    checks++; if (ro !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sm7_m2_r got %h want ffffffff", ro); end
    run32(1'b0, 32'hFFFF_FFF9, 32'd2, so, ro, dz, lat);
    checks++; if (so !== 32'h7FFF_FFFC) begin errors++; $display("FAIL ubig_2_s got %h want 7ffffffc", so); end
    checks++; if (ro !== 32'd1) begin errors++; $display("FAIL ubig_2_r got %h want 1", ro); end
  endtask

  task automatic test_div_zero();
    logic [31:0] so, ro; logic dz; int lat;
    run32(1'b1, 32'h1234_5678, 32'd0, so, ro, dz, lat);
    checks++; if (so !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_s got %h want ffffffff", so); end
    checks++; if (ro !== 32'h1234_5678) begin errors++; $display("FAIL dz_r got %h want 12345678", ro); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
  endtask

  task automatic test_overflow();
    logic [31:0] so, ro; logic dz; int lat;
    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, so, ro, dz, lat);
    checks++; if (so !== 32'h8000_0000) begin errors++; $display("FAIL ovf_s got %h want 80000000", so); end
    checks++; if (ro !== 32'd0) begin errors++; $display("FAIL ovf_r got %h want 0", ro); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b want 0", dz); end
  endtask

  task automatic test_backpressure();
    int lat; int bad = 0;
    start32(1'b0, 32'd100, 32'd7);
    wait32(lat);
    for (int i = 0; i < 10; i++) begin
      if (a_s !== 32'd14 || a_r !== 32'd2 || a_ir !== 1'b0 || a_ov !== 1'b1) bad++;
      @(posedge div_clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0 (s=%h r=%h)", bad, a_s, a_r); end
    a_or = 1'b1;
    @(posedge div_clk); #1;
    a_or = 1'b0;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", a_ir); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", a_ov); end
  endtask

  task automatic test_cancel();
    int lat; int rose = 0;
    start32(1'b0, 32'd1000, 32'd3);
    repeat (4) @(posedge div_clk);
    #1 a_cancel = 1'b1;
    @(posedge div_clk); #1;
    a_cancel = 1'b0;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL cancel_in_ready got %b want 1", a_ir); end
    checks++; if (a_s !== 32'd14 || a_r !== 32'd2) begin errors++; $display("FAIL cancel_keep got s=%h r=%h want e/2", a_s, a_r); end
    for (int i = 0; i < 40; i++) begin
      if (a_ov) rose++;
      @(posedge div_clk); #1;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL cancel_no_result got %0d valid cycles want 0", rose); end
    a_iv = 1'b1; a_cancel = 1'b1; a_y = 32'd5; a_x = 32'd20;
    @(posedge div_clk); #1;
    a_iv = 1'b0; a_cancel = 1'b0;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL cancel_idle_accept got in_ready=%b want 1", a_ir); end
    start32(1'b0, 32'd9, 32'd0);
    wait32(lat);
    a_cancel = 1'b1; a_or = 1'b1;
    @(posedge div_clk); #1;
    a_cancel = 1'b0; a_or = 1'b0;
    checks++; if (a_ov !== 1'b0 || a_ir !== 1'b1) begin errors++; $display("FAIL cancel_done got ov=%b ir=%b want 0/1", a_ov, a_ir); end
    checks++; if (a_r !== 32'd9 || a_dz !== 1'b1) begin errors++; $display("FAIL cancel_done_keep got r=%h dz=%b want 9/1", a_r, a_dz); end
  endtask

  task automatic test_reset_mid();
    start32(1'b0, 32'd50, 32'd5);
    repeat (3) @(posedge div_clk);
    #1 resetn = 1'b0;
    #1;
    checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin errors++; $display("FAIL rst_mid_hs got ir=%b ov=%b want 1/0", a_ir, a_ov); end
    checks++; if (a_s !== 32'd0 || a_r !== 32'd0 || a_dz !== 1'b0) begin errors++; $display("FAIL rst_mid_data got s=%h r=%h dz=%b want 0", a_s, a_r, a_dz); end
    @(posedge div_clk); #1 resetn = 1'b1;
  endtask

  task automatic test_params();
    logic [15:0] so, ro; logic dz; int lat;
    run16(1'b0, 16'd1000, 16'd7, so, ro, dz, lat);
    checks++; if (so !== 16'd142) begin errors++; $display("FAIL p16_s got %0d want 142", so); end
    checks++; if (ro !== 16'd6) begin errors++; $display("FAIL p16_r got %0d want 6", ro); end
    checks++; if (lat != 5) begin errors++; $display("FAIL p16_latency got %0d want 5", lat); end
    run16(1'b1, 16'hFC18, 16'd7, so, ro, dz, lat);
    checks++; if (so !== 16'hFF72 || ro !== 16'hFFFA) begin errors++; $display("FAIL p16_signed got s=%h r=%h want ff72/fffa", so, ro); end
    run16(1'b1, 16'h8000, 16'hFFFF, so, ro, dz, lat);
    checks++; if (so !== 16'h8000 || ro !== 16'h0000) begin errors++; $display("FAIL p16_ovf got s=%h r=%h want 8000/0", so, ro); end
  endtask

  task automatic test_random();
    logic [31:0] xv, yv, so, ro, es, er; logic [15:0] x16, y16, s16, r16, es16, er16;
    logic sg, dz, edz; int lat; longint xs, ys, q, rm;
    for (int i = 0; i < 12; i++) begin
      sg = 1'($urandom_range(0, 1));
      xv = $urandom;
      yv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if (sg) begin xs = longint'($signed(xv)); ys = longint'($signed(yv)); end
      else begin xs = longint'({32'd0, xv}); ys = longint'({32'd0, yv}); end
      if (yv == 0) begin es = 32'hFFFF_FFFF; er = xv; edz = 1'b1; end
      else begin q = xs / ys; rm = xs % ys; es = q[31:0]; er = rm[31:0]; edz = 1'b0; end
      run32(sg, xv, yv, so, ro, dz, lat);
      checks++; if (so !== es || ro !== er || dz !== edz)
        begin errors++; $display("FAIL rnd32 %0d x=%h y=%h sg=%b got %h/%h/%b want %h/%h/%b", i, xv, yv, sg, so, ro, dz, es, er, edz); end
    end
    for (int i = 0; i < 16; i++) begin
      sg = 1'($urandom_range(0, 1));
      x16 = 16'($urandom);
      y16 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
      if (sg) begin xs = longint'($signed(x16)); ys = longint'($signed(y16)); end
      else begin xs = longint'({48'd0, x16}); ys = longint'({48'd0, y16}); end
      if (y16 == 0) begin es16 = 16'hFFFF; er16 = x16; edz = 1'b1; end
      else begin q = xs / ys; rm = xs % ys; es16 = q[15:0]; er16 = rm[15:0]; edz = 1'b0; end
      run16(sg, x16, y16, s16, r16, dz, lat);
      checks++; if (s16 !== es16 || r16 !== er16 || dz !== edz)
        begin errors++; $display("FAIL rnd16 %0d x=%h y=%h sg=%b got %h/%h/%b want %h/%h/%b", i, x16, y16, sg, s16, r16, dz, es16, er16, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    test_params();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
